store_buffer: RTL and testbench

//  Posted-write FIFO between the core's load/store path and data_memory (single shared A port, async read, sync write).

---
 rtl/store_buffer.sv | 109 ++++++++++
 tb/tb_store_buffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer: stores are queued and drained to the shared data_memory port
// in program order, and loads forward the youngest matching buffered store.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    output logic                       ld_ready,
    output logic [DW-1:0]              ld_data,
    output logic                       ld_hit,
    output logic                       mem_we,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wd,
    input  logic [DW-1:0]              mem_rd,
    output logic                       sb_empty,
    output logic [$clog2(DEPTH):0]     sb_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             push;
    logic             pop;
    logic             load_sel;
    logic [PW-1:0]    fwd_idx;

    // A full buffer always drains so a stream of loads can never deadlock it.
    always_comb begin
        full     = (count == FULL_CNT);
        st_ready = !rst && !full;
        ld_ready = !rst && !full;
        push     = st_valid && st_ready;
        pop      = !rst && (count != '0) && (full || !ld_valid);
        load_sel = ld_valid && ld_ready;
        mem_we   = pop;
        mem_addr = '0;
        mem_wd   = '0;
        if (load_sel) begin
            mem_addr = ld_addr;
        end else if (pop) begin
            mem_addr = addr_q[rd_ptr];
            mem_wd   = data_q[rd_ptr];
        end
    end

    // Walk oldest to youngest so the last match found is the youngest store.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = mem_rd;
        fwd_idx = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if (valid_q[fwd_idx] && (addr_q[fwd_idx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = data_q[fwd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= st_addr;
            data_q[wr_ptr] <= st_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                wr_ptr          <= wr_ptr + PW'(1);
                valid_q[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr          <= rd_ptr + PW'(1);
                valid_q[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign sb_empty = (count == '0);
    assign sb_count = count;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: stimulus queues expected memory writes and load results,
// a monitor pops and compares them whenever the DUT writes memory or serves a load.
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_hit;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        sb_empty;
    logic [2:0]  sb_count;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    typedef struct packed {
        logic        h;
        logic [31:0] d;
    } ld_t;

    wr_t wq[$];
    ld_t lq[$];
    wr_t wexp;
    ld_t lexp;
    int  nvec;
    int  nfail;
    logic [31:0] mem [64];

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_hit(ld_hit),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .sb_empty(sb_empty), .sb_count(sb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_memory model: async read, sync write, preloaded with F000_0000 + index
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hF000_0000 + 32'(i);
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[5:0]] <= mem_wd;
    end
    assign mem_rd = mem[mem_addr[5:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        wq.push_back('{a: a, d: d});
    endtask

    task automatic exp_ld(input logic h, input logic [31:0] d);
        lq.push_back('{h: h, d: d});
    endtask

    // Monitor: every memory write and every served load must match the head of its queue.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            nvec++;
            if (wq.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, required no write",
                         mem_addr, mem_wd);
            end else begin
                wexp = wq.pop_front();
                if (mem_addr !== wexp.a || mem_wd !== wexp.d) begin
                    nfail++;
                    $display("FAIL drain_write: got addr=0x%0h data=0x%0h, required addr=0x%0h data=0x%0h",
                             mem_addr, mem_wd, wexp.a, wexp.d);
                end
            end
        end
        if (ld_valid === 1'b1 && ld_ready === 1'b1) begin
            nvec++;
            if (lq.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_load: got hit=%0b data=0x%0h, required load stalled",
                         ld_hit, ld_data);
            end else begin
                lexp = lq.pop_front();
                if (ld_hit !== lexp.h || ld_data !== lexp.d) begin
                    nfail++;
                    $display("FAIL load_result: addr=0x%0h got hit=%0b data=0x%0h, required hit=%0b data=0x%0h",
                             ld_addr, ld_hit, ld_data, lexp.h, lexp.d);
                end
            end
        end
    end

    initial begin
        nvec = 0;
        nfail = 0;
        rst = 1'b1;
        st_valid = 1'b1;
        st_addr = 32'd9;
        st_data = 32'hDEAD;
        ld_valid = 1'b1;
        ld_addr = 32'd3;

        // Reset: requests present but everything must stay blocked
        @(negedge clk);
        chk("rst_st_ready", 32'(st_ready), 32'h0);
        chk("rst_ld_ready", 32'(ld_ready), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        cyc();
        cyc();
        rst = 1'b0;
        st_valid = 1'b0;
        ld_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_st_ready", 32'(st_ready), 32'h1);
        chk("post_rst_ld_ready", 32'(ld_ready), 32'h1);
        chk("post_rst_empty", 32'(sb_empty), 32'h1);
        chk("post_rst_count", 32'(sb_count), 32'h0);

        // Single store drains the following cycle
        cyc();
        st_valid = 1'b1;
        st_addr = 32'd5;
        st_data = 32'h11;
        exp_wr(32'd5, 32'h11);
        cyc();
        st_valid = 1'b0;
        @(negedge clk);
        chk("t1_count", 32'(sb_count), 32'h1);
        cyc();
        @(negedge clk);
        chk("t1_empty", 32'(sb_empty), 32'h1);
        chk("t1_mem5", mem[5], 32'h11);

        // Loads held high fill the buffer; full forces a drain and stalls loads
        cyc();
        ld_valid = 1'b1;
        ld_addr = 32'd40;
        for (int i = 1; i <= 4; i++) begin
            st_valid = 1'b1;
            st_addr = 32'(i);
            st_data = 32'h100 + 32'(i);
            exp_ld(1'b0, 32'hF000_0028);
            cyc();
        end
        st_valid = 1'b0;
        exp_wr(32'd1, 32'h101);
        @(negedge clk);
        chk("t2_count_full", 32'(sb_count), 32'h4);
        chk("t2_st_ready", 32'(st_ready), 32'h0);
        chk("t2_ld_ready", 32'(ld_ready), 32'h0);
        chk("t2_mem_we", 32'(mem_we), 32'h1);
        cyc();
        exp_ld(1'b0, 32'hF000_0028);
        cyc();
        ld_valid = 1'b0;
        exp_wr(32'd2, 32'h102);
        exp_wr(32'd3, 32'h103);
        exp_wr(32'd4, 32'h104);
        repeat (3) cyc();
        @(negedge clk);
        chk("t2_empty", 32'(sb_empty), 32'h1);
        chk("t2_mem4", mem[4], 32'h104);

        // Forwarding: same-cycle store not seen, youngest match wins, miss reads memory
        st_valid = 1'b1;
        st_addr = 32'd20;
        st_data = 32'hA;
        ld_valid = 1'b1;
        ld_addr = 32'd20;
        exp_ld(1'b0, 32'hF000_0014);
        cyc();
        st_data = 32'hB;
        exp_ld(1'b1, 32'hA);
        cyc();
        st_valid = 1'b0;
        exp_ld(1'b1, 32'hB);
        @(negedge clk);
        chk("t3_count", 32'(sb_count), 32'h2);
        cyc();
        ld_addr = 32'd21;
        exp_ld(1'b0, 32'hF000_0015);
        cyc();
        ld_valid = 1'b0;
        exp_wr(32'd20, 32'hA);
        exp_wr(32'd20, 32'hB);
        repeat (2) cyc();
        @(negedge clk);
        chk("t3_mem20", mem[20], 32'hB);
        chk("t3_empty", 32'(sb_empty), 32'h1);

        // Push during a drain keeps count steady and order intact
        ld_valid = 1'b1;
        ld_addr = 32'd40;
        st_valid = 1'b1;
        st_addr = 32'd50;
        st_data = 32'h501;
        exp_ld(1'b0, 32'hF000_0028);
        cyc();
        st_addr = 32'd51;
        st_data = 32'h502;
        exp_ld(1'b0, 32'hF000_0028);
        cyc();
        ld_valid = 1'b0;
        st_addr = 32'd52;
        st_data = 32'h503;
        exp_wr(32'd50, 32'h501);
        exp_wr(32'd51, 32'h502);
        exp_wr(32'd52, 32'h503);
        cyc();
        st_valid = 1'b0;
        @(negedge clk);
        chk("t4_count_steady", 32'(sb_count), 32'h2);
        repeat (2) cyc();
        @(negedge clk);
        chk("t4_empty", 32'(sb_empty), 32'h1);
        chk("t4_mem52", mem[52], 32'h503);

        // Reset discards buffered stores without writing them
        ld_valid = 1'b1;
        ld_addr = 32'd40;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1;
            st_addr = 32'd60 + 32'(i);
            st_data = 32'h601 + 32'(i);
            exp_ld(1'b0, 32'hF000_0028);
            cyc();
        end
        st_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_count_before", 32'(sb_count), 32'h3);
        chk("t5_rst_mem_we", 32'(mem_we), 32'h0);
        chk("t5_rst_ld_ready", 32'(ld_ready), 32'h0);
        cyc();
        rst = 1'b0;
        ld_valid = 1'b0;
        @(negedge clk);
        chk("t5_count_after", 32'(sb_count), 32'h0);
        chk("t5_empty", 32'(sb_empty), 32'h1);
        repeat (3) cyc();
        for (int i = 0; i < 3; i++) begin
            chk("t5_mem_unchanged", mem[60 + i], 32'hF000_003C + 32'(i));
        end

        // Back-to-back stores to one address drain in order
        st_valid = 1'b1;
        st_addr = 32'd7;
        st_data = 32'd1;
        exp_wr(32'd7, 32'd1);
        exp_wr(32'd7, 32'd2);
        cyc();
        st_data = 32'd2;
        cyc();
        st_valid = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        chk("t6_mem7", mem[7], 32'd2);
        chk("t6_empty", 32'(sb_empty), 32'h1);

        repeat (2) cyc();
        chk("writes_outstanding", 32'(wq.size()), 32'h0);
        chk("loads_outstanding", 32'(lq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
